memory_pair_engine: RTL
=======================

// Module: memory_pair_engine
// PURPOSE
//   Parametrised cursor/selection/match engine for the memory-card game board.
//   Debounced-upstream move/select buttons drive a wrapping cursor over N_CARDS cards.
//   Two selections form one attempt: equal values are marked matched, unequal are
//   re-hidden after a show delay. Sits between button synchroniser and display/VGA logic.
// PARAMETERS
//   N_CARDS    16  number of cards on the board (even, >=2)
//   CARD_W     4   bits per card value
//   CNT_W      8   attempt counter width (saturating)
//   SHOW_CYC   4   cycles both picked cards stay revealed before compare (>=1)
// PORTS
//   clk        in   1                  system clock, rising edge
//   rst        in   1                  asynchronous active-low reset
//   move       in   1                  level; rising edge advances cursor
//   dir        in   1                  0 = cursor +1, 1 = cursor -1
//   select     in   1                  level; rising edge picks card under cursor
//   board      in   N_CARDS*CARD_W     card values, card i = board[i*CARD_W +: CARD_W]
//   cursor     out  $clog2(N_CARDS)    current cursor position
//   revealed   out  N_CARDS            1 = card face-up (picked, not yet resolved)
//   matched    out  N_CARDS            1 = card permanently matched
//   attempts   out  CNT_W              completed pair attempts
//   match_p    out  1                  1-cycle pulse on successful compare
//   miss_p     out  1                  1-cycle pulse on failed compare
//   done       out  1                  1 when all cards matched
// BEHAVIOUR
//   Reset (rst=0, async): cursor=0, revealed=0, matched=0, attempts=0, match_p=0,
//     miss_p=0, done=0, state=PICK1, edge-detect regs cleared to 0.
//   Edge detect: move_q/select_q register inputs; edge = in & ~in_q. Holding a
//     button high gives exactly one event. Button high during reset release -> no event.
//   Move: on move edge, cursor +/-1 per dir, wraps N_CARDS-1 <-> 0; new value visible
//     the cycle after the edge clock. Allowed in every state.
//   FSM states: PICK1, PICK2, SHOW, DONE.
//   PICK1: select edge on card with revealed=0 & matched=0 -> revealed[cursor]=1,
//     latch idx_a=cursor, go PICK2. Select on revealed/matched card ignored.
//   PICK2: valid select edge (card not revealed, not matched, != idx_a) -> set
//     revealed, latch idx_b, load show counter=SHOW_CYC-1, go SHOW. Else ignored.
//   SHOW: selects ignored. Counter decrements each cycle; at 0, compare
//     board[idx_a] vs board[idx_b] (board sampled at compare cycle):
//     equal -> matched[a],[b]=1, match_p=1; unequal -> miss_p=1.
//     Both cases: revealed[a],[b]=0, attempts+=1 (saturates at 2^CNT_W-1), go PICK1,
//     or DONE if matched becomes all-ones. Pulses last exactly one cycle.
//   SHOW latency: 2nd select edge clock -> SHOW_CYC clocks -> pulse/flags update.
//   DONE: done=1, all select edges ignored, cursor still moves; exit only by reset.
//   Simultaneous move+select edge: select uses pre-move cursor; cursor moves too.
//   Reset mid-SHOW: everything returns to reset values; no pulse, no count.
//   All outputs registered; no combinational input->output paths.
// TESTING
//   T1 reset: hold rst=0, toggle clk -> all outputs 0; release, move held 1 -> cursor 0.
//   T2 wrap: 17 move edges dir=0 (N=16) -> cursor 1; then 2 edges dir=1 -> cursor 15.
//   T3 match: board c0=c1=4'h3, select@0, move, select@1 -> revealed=0x0003 for 4 cycles,
//      then match_p=1 one cycle, matched=0x0003, revealed=0, attempts=1.
//   T4 miss: c2=5, c3=6, pick 2 then 3 -> after SHOW_CYC miss_p=1, revealed=0,
//      matched unchanged, attempts=2; re-select of a matched card or same card ignored.
//   T5 done/saturate: CNT_W=2, play all 8 pairs with 3 misses first -> attempts=3 held,
//      done=1 after last match, further selects no effect.
//   T6 reset mid-SHOW: rst=0 two cycles into SHOW -> no pulse, revealed=0, attempts=0.

Source files
------------

// File: rtl/memory_pair_engine_if.sv
// ----------------------------------------------------------------------------
// memory_pair_engine_if
//   Groups the button inputs, the board values and the game-state outputs of
//   the memory-card engine into one bundle.
//   master : the side that drives the buttons and board (synchroniser / bench)
//   slave  : the engine itself
// Signals
//   move, dir, select : button levels (debounced upstream)
//   board             : N_CARDS*CARD_W card values, card i at [i*CARD_W +: CARD_W]
//   cursor            : current cursor position
//   revealed, matched : per-card face-up / permanently-matched flags
//   attempts          : completed pair attempts (saturating)
//   match_p, miss_p   : one-cycle result pulses
//   done              : all cards matched
// ----------------------------------------------------------------------------
interface memory_pair_engine_if #(
    parameter int N_CARDS = 16,
    parameter int CARD_W  = 4,
    parameter int CNT_W   = 8
);
    localparam int CUR_W = $clog2(N_CARDS);

    logic                        move;
    logic                        dir;
    logic                        select;
    logic [N_CARDS*CARD_W-1:0]   board;
    logic [CUR_W-1:0]            cursor;
    logic [N_CARDS-1:0]          revealed;
    logic [N_CARDS-1:0]          matched;
    logic [CNT_W-1:0]            attempts;
    logic                        match_p;
    logic                        miss_p;
    logic                        done;

    modport master (
        output move, dir, select, board,
        input  cursor, revealed, matched, attempts, match_p, miss_p, done
    );

    modport slave (
        input  move, dir, select, board,
        output cursor, revealed, matched, attempts, match_p, miss_p, done
    );
endinterface

// File: rtl/memory_pair_engine.sv
// ----------------------------------------------------------------------------
// memory_pair_engine
//   Cursor / selection / match engine for the memory-card game board.
//   Move and select buttons are edge-detected; the cursor wraps over N_CARDS
//   cards. Two selections form one attempt: equal values become matched,
//   unequal ones are hidden again after SHOW_CYC cycles on display.
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : memory_pair_engine_if.slave (buttons, board in; game state out)
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module memory_pair_engine #(
    parameter int N_CARDS  = 16,
    parameter int CARD_W   = 4,
    parameter int CNT_W    = 8,
    parameter int SHOW_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    memory_pair_engine_if.slave   bus
);
    localparam int CUR_W = $clog2(N_CARDS);
    localparam int SHW_W = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
    localparam logic [CUR_W-1:0] LAST_CARD = CUR_W'(N_CARDS - 1);

    typedef enum logic [1:0] {PICK1, PICK2, SHOW, DONE} state_t;

    state_t               r_state;
    logic                 r_move_q;
    logic                 r_select_q;
    logic                 r_armed;
    logic [CUR_W-1:0]     r_cursor;
    logic [CUR_W-1:0]     r_idx_a;
    logic [CUR_W-1:0]     r_idx_b;
    logic [SHW_W-1:0]     r_show_cnt;
    logic [N_CARDS-1:0]   r_revealed;
    logic [N_CARDS-1:0]   r_matched;
    logic [CNT_W-1:0]     r_attempts;
    logic                 r_match_p;
    logic                 r_miss_p;
    logic                 r_done;

    logic                 w_move_edge;
    logic                 w_select_edge;
    logic                 w_cur_free;
    logic                 w_equal;
    logic [N_CARDS-1:0]   w_pair_mask;
    logic [N_CARDS-1:0]   w_matched_hit;
    logic [CARD_W-1:0]    w_cards [N_CARDS];

    // Unpack the flat board bus into one value per card.
    for (genvar gi = 0; gi < N_CARDS; gi++) begin : g_cards
        assign w_cards[gi] = bus.board[gi*CARD_W +: CARD_W];
    end

    // r_armed stays low for the first clock after reset so that a button
    // already held during reset release is absorbed instead of firing.
    assign w_move_edge   = r_armed & bus.move   & ~r_move_q;
    assign w_select_edge = r_armed & bus.select & ~r_select_q;

    // A card can be picked only while face-down and unmatched; this also
    // rejects re-picking the first card of the pair, which is revealed.
    assign w_cur_free    = ~r_revealed[r_cursor] & ~r_matched[r_cursor];

    assign w_pair_mask   = (N_CARDS'(1) << r_idx_a) | (N_CARDS'(1) << r_idx_b);
    assign w_equal       = (w_cards[r_idx_a] == w_cards[r_idx_b]);
    assign w_matched_hit = r_matched | w_pair_mask;

    // Button edge registers and the wrapping cursor. The cursor moves in every
    // game state, including DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_move_q   <= 1'b0;
            r_select_q <= 1'b0;
            r_armed    <= 1'b0;
            r_cursor   <= '0;
        end else begin
            r_move_q   <= bus.move;
            r_select_q <= bus.select;
            r_armed    <= 1'b1;
            if (w_move_edge) begin
                if (!bus.dir) begin
                    r_cursor <= (r_cursor == LAST_CARD) ? '0 : r_cursor + 1'b1;
                end else begin
                    r_cursor <= (r_cursor == '0) ? LAST_CARD : r_cursor - 1'b1;
                end
            end
        end
    end

    // Game FSM. Selection reads the pre-move cursor, so a simultaneous
    // move+select picks the card the cursor is leaving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= PICK1;
            r_idx_a    <= '0;
            r_idx_b    <= '0;
            r_show_cnt <= '0;
            r_revealed <= '0;
            r_matched  <= '0;
            r_attempts <= '0;
            r_match_p  <= 1'b0;
            r_miss_p   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_match_p <= 1'b0;
            r_miss_p  <= 1'b0;
            case (r_state)
                PICK1: begin
                    if (w_select_edge && w_cur_free) begin
                        r_revealed[r_cursor] <= 1'b1;
                        r_idx_a              <= r_cursor;
                        r_state              <= PICK2;
                    end
                end
                PICK2: begin
                    if (w_select_edge && w_cur_free) begin
                        r_revealed[r_cursor] <= 1'b1;
                        r_idx_b              <= r_cursor;
                        r_show_cnt           <= SHW_W'(SHOW_CYC - 1);
                        r_state              <= SHOW;
                    end
                end
                SHOW: begin
                    if (r_show_cnt != '0) begin
                        r_show_cnt <= r_show_cnt - 1'b1;
                    end else begin
                        r_revealed <= r_revealed & ~w_pair_mask;
                        if (w_equal) begin
                            r_matched <= w_matched_hit;
                            r_match_p <= 1'b1;
                        end else begin
                            r_miss_p  <= 1'b1;
                        end
                        if (r_attempts != '1) begin
                            r_attempts <= r_attempts + 1'b1;
                        end
                        if (w_equal && (&w_matched_hit)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= PICK1;
                        end
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= PICK1;
                end
            endcase
        end
    end

    assign bus.cursor   = r_cursor;
    assign bus.revealed = r_revealed;
    assign bus.matched  = r_matched;
    assign bus.attempts = r_attempts;
    assign bus.match_p  = r_match_p;
    assign bus.miss_p   = r_miss_p;
    assign bus.done     = r_done;
endmodule
